alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, the datapath width matching the ALU.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, the destination register address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  the upstream ALU result is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the block accepts the input this cycle.
REQ-007 SHALL have port in_mode  input  4  the ALU mode_select that produced the result.
REQ-008 SHALL have port in_dest  input  REG_ADDR_W  the destination register.
REQ-009 SHALL have port in_result  input  WORD_SIZE  the ALU output_C.
REQ-010 SHALL have port in_flags  input  8  the ALU flags: [7] Z, [6] S, [5] C, [4] O.
REQ-011 SHALL have port flush  input  1  a synchronous discard of all pending writebacks.
REQ-012 SHALL have port wb_valid  output  1  a register-file write is pending.
REQ-013 SHALL have port wb_ready  input  1  the register file accepts the write.
REQ-014 SHALL have port wb_addr  output  REG_ADDR_W, and port wb_data  output  WORD_SIZE, giving the head-entry write address and data.
REQ-015 SHALL have port flags_q  output  8  the architectural flags register.
REQ-016 SHALL have port busy  output  1  high when count != 0.

Function
REQ-017 SHALL hold pending writebacks in a 2-entry FIFO (dest, result), with a count of 0..2 and 1-bit wrapping read/write pointers.
REQ-018 SHALL drive in_ready = !flush && (count < 2), registered-state-only, with no combinational path from wb_ready.
REQ-019 SHALL treat an input as accepted when in_valid && in_ready at the rising edge.
REQ-020 SHALL push an accepted input into the FIFO only for a writing mode: 1, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13 or 14.
REQ-021 SHALL consume an accepted input for flags only, with no push, for modes 0, 2, 3 and 15.
REQ-022 SHALL update flags_q on acceptance by mode:
- modes 2, 3, 6-9, 11-13: bits [7:4] taken from in_flags;
- modes 4, 5: bits [7:5] taken from in_flags, [4] held;
- mode 10: bits [7:6] taken from in_flags, [5:4] held;
- modes 0, 1, 14: flags_q unchanged;
- mode 15: flags_q cleared to 0.
REQ-023 SHALL force flags_q[3:0] to 0 at all times.
REQ-024 SHALL drive wb_valid = (count != 0), with wb_addr/wb_data taken from the head entry.
REQ-025 SHALL pop the head when wb_valid && wb_ready.
REQ-026 SHALL give a latency of one cycle: an input accepted at edge N into an empty FIFO raises wb_valid after edge N.
REQ-027 SHALL apply a simultaneous push and pop in the same edge, leaving count unchanged and data order preserved.
REQ-028 SHALL hold wb_addr/wb_data stable while wb_valid && !wb_ready.
REQ-029 SHALL, on flush, set count to 0 and reset both pointers at the next edge, leave flags_q unchanged, and ignore any pop in that cycle.
REQ-030 SHALL leave writes to the same register ordered, with the younger entry written later.

Reset
REQ-031 SHALL, while reset_n is low, asynchronously force count=0, pointers=0 and flags_q=8'h00, giving wb_valid=0, busy=0 and in_ready=1 (when flush is low).
REQ-032 SHALL discard in-flight FIFO contents on reset mid-operation, with no partial write emitted.
REQ-033 SHALL leave FIFO data storage unreset, unobservable while count=0.

Structure
REQ-034 SHALL place the ALU mode encodings (0-15) and the flag bit indices (ZERO=7, SIGN=6, CARRY=5, OVERFLOW=4) in a shared package, alu_pkg, also imported by the ALU.
REQ-035 SHALL place the flag-update mask decode (mode -> 4-bit update mask, write-enable, clear) in one combinational function in alu_pkg.
REQ-036 SHALL implement the FIFO as the sub-module wb_fifo2, parameterised on entry width.

Verification
REQ-037 SHALL cover: mode 6, dest 3, result 8'h10, flags 8'h20, wb_ready=1 -> wb_valid next cycle with addr 3, data 8'h10, flags_q=8'h20.
REQ-038 SHALL cover: mode 2 with flags 8'hC0 -> no wb_valid and flags_q=8'hC0; then mode 15 -> flags_q=8'h00.
REQ-039 SHALL cover: mode 4 with flags 8'h30 after flags_q=8'h90 -> flags_q=8'h30, with the bit-4 value held from before (result 8'h30).
REQ-040 SHALL cover: wb_ready=0 and three writing inputs (dest 1, 2, 3) -> in_ready low after two; then wb_ready=1 -> writes 1, 2, 3 in order.
REQ-041 SHALL cover: count=2 plus flush -> wb_valid=0 next cycle, flags_q unchanged, in_ready=1.
REQ-042 SHALL cover: reset_n low mid-transfer with count=1 -> wb_valid=0 immediately (asynchronously) and flags_q=8'h00.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU mode encodings, flag bit indices and flag-update decode
package alu_pkg;

   typedef enum logic [3:0] {
      MODE_0  = 4'd0,  MODE_1  = 4'd1,  MODE_2  = 4'd2,  MODE_3  = 4'd3,
      MODE_4  = 4'd4,  MODE_5  = 4'd5,  MODE_6  = 4'd6,  MODE_7  = 4'd7,
      MODE_8  = 4'd8,  MODE_9  = 4'd9,  MODE_10 = 4'd10, MODE_11 = 4'd11,
      MODE_12 = 4'd12, MODE_13 = 4'd13, MODE_14 = 4'd14, MODE_15 = 4'd15
   } alu_mode_e;

   localparam int FLAG_ZERO     = 7;
   localparam int FLAG_SIGN     = 6;
   localparam int FLAG_CARRY    = 5;
   localparam int FLAG_OVERFLOW = 4;

   // mask bit i selects flag bit FLAG_OVERFLOW+i for update from the ALU
   typedef struct packed {
      logic [3:0] mask;
      logic       we;
      logic       clr;
   } flag_upd_t;

   function automatic flag_upd_t flag_decode(input logic [3:0] mode);
      flag_upd_t upd;
      upd.mask = 4'h0;
      upd.we   = 1'b0;
      upd.clr  = 1'b0;
      case (mode)
         MODE_2, MODE_3, MODE_6, MODE_7, MODE_8, MODE_9,
         MODE_11, MODE_12, MODE_13: begin
            upd.mask = 4'hF;
            upd.we   = 1'b1;
         end
         MODE_4, MODE_5: begin
            upd.mask = 4'hE;
            upd.we   = 1'b1;
         end
         MODE_10: begin
            upd.mask = 4'hC;
            upd.we   = 1'b1;
         end
         MODE_15: upd.clr = 1'b1;
         default: ;
      endcase
      return upd;
   endfunction

   function automatic logic mode_writes_reg(input logic [3:0] mode);
      return !(mode inside {MODE_0, MODE_2, MODE_3, MODE_15});
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry writeback FIFO with synchronous flush
module wb_fifo2 #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   assign push_ok = push && (count_q != 2'd2);
   assign pop_ok  = pop && (count_q != 2'd0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) wr_ptr_d = ~wr_ptr_q;
         if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage is not reset: contents are only visible while count is non-zero
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback queue and architectural flags register
module alu_writeback
   import alu_pkg::*;
#(
   parameter int WORD_SIZE  = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_mode,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [WORD_SIZE-1:0]  in_result,
   input  logic [7:0]            in_flags,
   input  logic                  flush,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [WORD_SIZE-1:0]  wb_data,
   output logic [7:0]            flags_q,
   output logic                  busy
);

   localparam int ENTRY_W = REG_ADDR_W + WORD_SIZE;

   logic [1:0]         count;
   logic [ENTRY_W-1:0] head;
   logic               accept, push, pop;
   logic [3:0]         flags_hi_q, flags_hi_d;
   flag_upd_t          upd;
   logic               unused_flags;

   assign in_ready = !flush && (count != 2'd2);
   assign accept   = in_valid && in_ready;
   assign push     = accept && mode_writes_reg(in_mode);
   assign pop      = wb_valid && wb_ready;

   wb_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push),
      .push_data ({in_dest, in_result}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   assign wb_valid           = (count != 2'd0);
   assign busy               = wb_valid;
   assign {wb_addr, wb_data} = head;

   always_comb begin
      upd        = flag_decode(in_mode);
      flags_hi_d = flags_hi_q;
      if (accept) begin
         if (upd.clr)
            flags_hi_d = 4'h0;
         else if (upd.we)
            flags_hi_d = (flags_hi_q & ~upd.mask) |
                         (in_flags[FLAG_ZERO:FLAG_OVERFLOW] & upd.mask);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) flags_hi_q <= 4'h0;
      else          flags_hi_q <= flags_hi_d;
   end

   // low nibble of the flags register is architecturally always zero
   assign flags_q      = {flags_hi_q, 4'h0};
   assign unused_flags = ^in_flags[3:0];

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - randomized and directed self-checking bench for alu_writeback
module tb_alu_writeback;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid, in_ready;
   logic [3:0] in_mode;
   logic [2:0] in_dest;
   logic [7:0] in_result, in_flags;
   logic       flush;
   logic       wb_valid, wb_ready;
   logic [2:0] wb_addr;
   logic [7:0] wb_data, flags_q;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [2:0] a; logic [7:0] d; } ent_t;
   ent_t       mq[$];
   logic [7:0] m_flags;

   always #5 clk = ~clk;

   alu_writeback #(.WORD_SIZE(8), .REG_ADDR_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_dest(in_dest), .in_result(in_result), .in_flags(in_flags),
      .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
      .wb_data(wb_data), .flags_q(flags_q), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_writes(input logic [3:0] m);
      return m inside {4'd1, [4'd4:4'd14]};
   endfunction

   function automatic logic [7:0] ref_flags(input logic [7:0] old, input logic [3:0] m,
                                            input logic [7:0] f);
      if (m inside {4'd2, 4'd3, [4'd6:4'd9], [4'd11:4'd13]}) return {f[7:4], 4'h0};
      if (m inside {4'd4, 4'd5})                             return {f[7:5], old[4], 4'h0};
      if (m == 4'd10)                                        return {f[7:6], old[5:4], 4'h0};
      if (m == 4'd15)                                        return 8'h00;
      return old;
   endfunction

   task automatic drive(input bit v, input logic [3:0] m, input logic [2:0] d,
                        input logic [7:0] r, input logic [7:0] f);
      in_valid = v; in_mode = m; in_dest = d; in_result = r; in_flags = f;
   endtask

   // compare against the model, then advance model and DUT by one clock edge
   task automatic tick();
      bit   acc, pop;
      ent_t e;
      #1;
      chk("in_ready", in_ready, (!flush && mq.size() < 2));
      chk("wb_valid", wb_valid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("wb_addr", wb_addr, mq[0].a);
         chk("wb_data", wb_data, mq[0].d);
      end
      chk("flags_q", flags_q, m_flags);
      acc = in_valid && !flush && (mq.size() < 2);
      pop = (mq.size() != 0) && wb_ready;
      if (flush) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (acc && ref_writes(in_mode)) begin
            e.a = in_dest; e.d = in_result;
            mq.push_back(e);
         end
      end
      if (acc) m_flags = ref_flags(m_flags, in_mode, in_flags);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0] got[$];
      logic [7:0] saved_flags;
      bit         pending;

      reset_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      mq.delete(); m_flags = 8'h00;
      @(posedge clk); #1;
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_flags", flags_q, 8'h00);
      reset_n = 1'b1;

      // single writing result, one-cycle latency
      drive(1, 4'd6, 3'd3, 8'h10, 8'h20); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      chk("lat_wb_valid", wb_valid, 1'b1);
      chk("lat_wb_addr", wb_addr, 3'd3);
      chk("lat_wb_data", wb_data, 8'h10);
      chk("lat_flags", flags_q, 8'h20);
      tick();

      // flags-only mode then clear
      drive(1, 4'd2, 3'd5, 8'hAA, 8'hC0); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      chk("m2_wb_valid", wb_valid, 1'b0);
      chk("m2_flags", flags_q, 8'hC0);
      drive(1, 4'd15, 3'd0, 8'h00, 8'hF0); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      chk("m15_flags", flags_q, 8'h00);

      // partial update holds the overflow bit
      drive(1, 4'd2, 3'd0, 8'h00, 8'h90); tick();
      drive(1, 4'd4, 3'd2, 8'h30, 8'h30); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      chk("m4_flags", flags_q, 8'h30);
      tick();

      // back-pressure: three writes with the register file stalled
      wb_ready = 1'b0;
      drive(1, 4'd1, 3'd1, 8'h11, 8'h00); tick();
      drive(1, 4'd1, 3'd2, 8'h22, 8'h00); tick();
      drive(1, 4'd1, 3'd3, 8'h33, 8'h00);
      #1;
      chk("full_in_ready", in_ready, 1'b0);
      tick();
      wb_ready = 1'b1;
      pending = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (wb_valid && wb_ready) got.push_back(wb_addr);
         if (pending && in_ready) begin
            tick();
            pending = 1'b0;
            drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
         end else tick();
      end
      chk("order_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("order_0", got[0], 3'd1);
         chk("order_1", got[1], 3'd2);
         chk("order_2", got[2], 3'd3);
      end

      // flush with a full queue
      wb_ready = 1'b0;
      drive(1, 4'd1, 3'd5, 8'h55, 8'h00); tick();
      drive(1, 4'd7, 3'd6, 8'h66, 8'h50); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      saved_flags = flags_q;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_wb_valid", wb_valid, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_flags", flags_q, saved_flags);

      // asynchronous reset with one entry in flight
      drive(1, 4'd6, 3'd4, 8'h44, 8'hF0); tick();
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      chk("pre_rst_valid", wb_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_wb_valid", wb_valid, 1'b0);
      chk("arst_flags", flags_q, 8'h00);
      chk("arst_busy", busy, 1'b0);
      mq.delete(); m_flags = 8'h00;
      @(posedge clk); #1;
      reset_n = 1'b1;
      wb_ready = 1'b1;

      // randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), 3'($urandom),
               8'($urandom), 8'($urandom));
         flush    = ($urandom_range(0, 19) == 0);
         wb_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      flush = 1'b0; wb_ready = 1'b1;
      drive(0, 4'd0, 3'd0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
